// File: rtl/rf_writeback_unit.sv
// rtl/rf_writeback_unit.sv - register-file write-port arbiter with 2-entry long-latency buffer and busy scoreboard
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_wb_valid/ready/addr/data  single-cycle result stream
//   lsu_wb_valid/ready/addr/data  long-latency result stream
//   issue_long_valid/addr         marks a long-latency destination busy
//   rs1, rs2 / rs1_busy, rs2_busy decode-stage hazard query (combinational)
//   write_en/addr/data            registered register-file write port

module rf_writeback_unit #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_wb_valid,
    output logic                      alu_wb_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_wb_addr,
    input  logic [XPR_LEN-1:0]        alu_wb_data,
    input  logic                      lsu_wb_valid,
    output logic                      lsu_wb_ready,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_wb_addr,
    input  logic [XPR_LEN-1:0]        lsu_wb_data,
    input  logic                      issue_long_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_long_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      write_en,
    output logic [REG_ADDR_WIDTH-1:0] write_addr,
    output logic [XPR_LEN-1:0]        write_data
);

    localparam int NREGS = 2 ** REG_ADDR_WIDTH;

    // Two-entry in-order buffer for long-latency results
    logic [REG_ADDR_WIDTH-1:0] fifo_addr_q [2];
    logic [XPR_LEN-1:0]        fifo_data_q [2];
    logic                      rd_ptr_q, rd_ptr_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic [1:0]                count_q, count_d;

    logic                      write_en_q, write_en_d;
    logic [REG_ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [XPR_LEN-1:0]        write_data_q, write_data_d;

    logic [NREGS-1:0]          busy_q, busy_d;

    logic                      accept;
    logic                      alu_fire, lsu_fire;
    logic                      push, pop;
    logic                      sel_valid;
    logic [REG_ADDR_WIDTH-1:0] sel_addr;
    logic [XPR_LEN-1:0]        sel_data;

    // Readiness depends on occupancy only, so a full buffer stalls both producers
    assign accept       = (count_q != 2'd2);
    assign alu_wb_ready = accept;
    assign lsu_wb_ready = accept;
    assign alu_fire     = alu_wb_valid & accept;
    assign lsu_fire     = lsu_wb_valid & accept;

    // Source selection: full buffer drains first, then ALU, then buffered
    // results, then a direct LSU bypass when the buffer is empty.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        if (count_q == 2'd2) begin
            pop = 1'b1;
        end else if (alu_fire) begin
            sel_valid = 1'b1;
            sel_addr  = alu_wb_addr;
            sel_data  = alu_wb_data;
            push      = lsu_fire;
        end else if (count_q != 2'd0) begin
            pop  = 1'b1;
            push = lsu_fire;
        end else if (lsu_fire) begin
            sel_valid = 1'b1;
            sel_addr  = lsu_wb_addr;
            sel_data  = lsu_wb_data;
        end
        if (pop) begin
            sel_valid = 1'b1;
            sel_addr  = fifo_addr_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // x0 results are consumed but never reach the register file
    always_comb begin
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (sel_valid && (sel_addr != '0)) begin
            write_en_d   = 1'b1;
            write_addr_d = sel_addr;
            write_data_d = sel_data;
        end
    end

    // Clear follows the registered write port so busy drops only once the
    // register file holds the value; a same-cycle issue overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (write_en_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (issue_long_valid && (issue_long_addr != '0)) begin
            busy_d[issue_long_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            fifo_addr_q[0] <= '0;
            fifo_addr_q[1] <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            write_en_q     <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            busy_q         <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            if (push) begin
                fifo_addr_q[wr_ptr_q] <= lsu_wb_addr;
                fifo_data_q[wr_ptr_q] <= lsu_wb_data;
            end
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign rs1_busy   = busy_q[rs1];
    assign rs2_busy   = busy_q[rs2];

endmodule

// File: tb/tb_rf_writeback_unit.sv
// tb/tb_rf_writeback_unit.sv - randomized and directed check of rf_writeback_unit against a queue model

module tb_rf_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_wb_valid, alu_wb_ready;
    logic [4:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;
    logic        lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  lsu_wb_addr;
    logic [31:0] lsu_wb_data;
    logic        issue_long_valid;
    logic [4:0]  issue_long_addr;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    rf_writeback_unit #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .issue_long_valid(issue_long_valid), .issue_long_addr(issue_long_addr),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending buffered results, expected write port, busy set
    wb_t         fq[$];
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_busy [32];
    int          max_depth;
    int          wr_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        fq.delete();
        exp_we = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
        for (int i = 0; i < 32; i++) exp_busy[i] = 1'b0;
    endtask

    // One cycle: drive, compare DUT against model, then advance the model
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ia,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit   room, at, lt, have;
        wb_t  sel, e;
        @(posedge clk);
        #2;
        alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
        lsu_wb_valid = lv; lsu_wb_addr = la; lsu_wb_data = ld;
        issue_long_valid = iv; issue_long_addr = ia;
        rs1 = r1; rs2 = r2;
        #2;
        room = (fq.size() < 2);
        check("alu_ready", alu_wb_ready, room);
        check("lsu_ready", lsu_wb_ready, room);
        check("write_en", write_en, exp_we);
        check("write_addr", write_addr, exp_wa);
        check("write_data", write_data, exp_wd);
        check("rs1_busy", rs1_busy, exp_busy[r1]);
        check("rs2_busy", rs2_busy, exp_busy[r2]);
        if (exp_we) wr_log.push_back(int'(exp_wa));

        if (exp_we) exp_busy[exp_wa] = 1'b0;
        if (iv && ia != 0) exp_busy[ia] = 1'b1;

        at = av && room;
        lt = lv && room;
        e.a = la; e.d = ld;
        have = 1'b1;
        if (fq.size() == 2) begin
            sel = fq.pop_front();
        end else if (at) begin
            sel.a = aa; sel.d = ad;
            if (lt) fq.push_back(e);
        end else if (fq.size() > 0) begin
            sel = fq.pop_front();
            if (lt) fq.push_back(e);
        end else if (lt) begin
            sel = e;
        end else begin
            have = 1'b0;
            sel  = '0;
        end
        if (fq.size() > max_depth) max_depth = fq.size();
        if (have && sel.a != 0) begin
            exp_we = 1'b1; exp_wa = sel.a; exp_wd = sel.d;
        end else begin
            exp_we = 1'b0;
        end
    endtask

    task automatic idle(input int n, input logic [4:0] r1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        int lsu_left;
        logic [4:0] ra;
        rst_n = 1'b0;
        alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
        issue_long_valid = 0; issue_long_addr = 0; rs1 = 0; rs2 = 0;
        max_depth = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check("rst_write_en", write_en, 1'b0);
        check("rst_alu_ready", alu_wb_ready, 1'b1);
        check("rst_lsu_ready", lsu_wb_ready, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // ALU write to x5 appears on the port one cycle later, for one cycle
        wr_log.delete();
        step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        check("x5_single_write", wr_log.size(), 1);

        // Long op to x7, LSU result three cycles later
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(2, 7);
        step(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0, 7, 0);
        idle(3, 7);

        // ALU x1 with LSU x2, then ALU x3: order x1, x3, x2
        wr_log.delete();
        max_depth = 0;
        step(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0);
        step(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        check("order_len", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("order_0", wr_log[0], 1);
            check("order_1", wr_log[1], 3);
            check("order_2", wr_log[2], 2);
        end
        check("peak_depth_1", max_depth, 1);

        // Continuous ALU traffic with three held LSU results
        max_depth = 0;
        lsu_left = 3;
        for (int i = 0; i < 8; i++) begin
            bit acc;
            acc = (fq.size() < 2);
            step(1, 5'(10 + i), 32'hA000 + i, lsu_left > 0, 5'(20 + lsu_left),
                 32'hB000 + lsu_left, 0, 0, 0, 0);
            if (acc && lsu_left > 0) lsu_left--;
        end
        idle(4, 0);
        check("peak_depth_2", max_depth, 2);
        check("lsu_all_taken", lsu_left, 0);

        // x0 traffic: consumed, never written, never busy
        wr_log.delete();
        step(1, 0, 32'h5, 1, 0, 32'h6, 1, 0, 0, 0);
        idle(3, 0);
        check("x0_no_write", wr_log.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic iv;
            ra = 5'($urandom_range(0, 7));
            iv = ($urandom_range(0, 3) == 0) && !exp_busy[ra];
            step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 iv, ra, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(4, 0);

        // Fill the buffer with x9 pending, then reset mid-cycle
        step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        step(1, 12, 32'hC1, 1, 13, 32'hC2, 0, 0, 9, 0);
        step(1, 14, 32'hC3, 1, 15, 32'hC4, 0, 0, 9, 0);
        check("full_before_reset", fq.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_write_en", write_en, 1'b0);
        check("arst_write_addr", write_addr, 5'd0);
        check("arst_write_data", write_data, 32'd0);
        check("arst_alu_ready", alu_wb_ready, 1'b1);
        check("arst_lsu_ready", lsu_wb_ready, 1'b1);
        check("arst_rs1_busy", rs1_busy, 1'b0);
        model_reset();
        alu_wb_valid = 0; lsu_wb_valid = 0; issue_long_valid = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        wr_log.delete();
        idle(4, 9);
        check("no_stale_write", wr_log.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_writeback_unit.md
# rf_writeback_unit

Write-side front end for the integer register file. Accepts results from the single-cycle ALU path and the long-latency load/store/multi-cycle path, arbitrates them onto the register file's single write port (`write_en`/`write_addr`/`write_data`), and buffers up to two long-latency results. A per-register scoreboard reports `rs1`/`rs2` hazards so the decode stage can stall until a pending destination has been written.

## Interface
- `XPR_LEN`, 32, data width; matches the register file.
- `REG_ADDR_WIDTH`, 5, register address width; 32 architectural registers.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alu_wb_valid`  in  1  ALU result present.
- `alu_wb_ready`  out  1  ALU result accepted this cycle.
- `alu_wb_addr`  in  REG_ADDR_WIDTH  ALU destination.
- `alu_wb_data`  in  XPR_LEN  ALU result.
- `lsu_wb_valid`  in  1  long-latency result present.
- `lsu_wb_ready`  out  1  long-latency result accepted this cycle.
- `lsu_wb_addr`  in  REG_ADDR_WIDTH  long-latency destination.
- `lsu_wb_data`  in  XPR_LEN  long-latency result.
- `issue_long_valid`  in  1  long-latency op issued this cycle; marks destination busy.
- `issue_long_addr`  in  REG_ADDR_WIDTH  destination of the issued op.
- `rs1`, `rs2`  in  REG_ADDR_WIDTH  decode-stage source addresses.
- `rs1_busy`, `rs2_busy`  out  1  source has a pending long-latency write (combinational).
- `write_en`, `write_addr`, `write_data`  out  1 / REG_ADDR_WIDTH / XPR_LEN  registered register-file write port.

## Operation
- Handshakes: transfer occurs in a cycle where valid and ready are both high. Ready is combinational from the FIFO count only, never from valid.
  - `lsu_wb_ready` = (count < 2).
  - `alu_wb_ready` = (count < 2).
- FIFO: 2 entries `{addr, data}`, in-order, count 0..2.
- Per-cycle source selection, first match wins:
  1. count == 2: FIFO head is popped and written. ALU and LSU are not accepted because both readies are low.
  2. ALU transfer: ALU result is written. An LSU transfer in the same cycle is pushed into the FIFO.
  3. count > 0: FIFO head is popped and written. An LSU transfer in the same cycle is pushed; push and pop together leave the count unchanged.
  4. LSU transfer with count == 0: LSU result is written directly and not pushed.
  5. Otherwise nothing is selected.
- Output register:
  - If a source is selected and its address != 0: `write_en` <= 1, `write_addr`/`write_data` <= selected values.
  - Otherwise: `write_en` <= 0, and `write_addr`/`write_data` hold their previous values.
  - A selected entry with address 0 is consumed and discarded.
- Scoreboard: 32 busy bits; bit 0 is hardwired to 0.
  - Set on `issue_long_valid` for a nonzero `issue_long_addr`.
  - Cleared at the edge where the registered `write_en` = 1 and `write_addr` matches. This is the same edge on which the register file stores the data.
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes clear bits like any other write. Upstream guarantees no second long op is issued to a busy register.
- `rsN_busy` = busy[rsN]. It reads 0 for `rsN` == 0.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `write_en` = 0, `write_addr` = 0, `write_data` = 0.
  - FIFO count = 0, all busy bits = 0.
  - `alu_wb_ready` = 1, `lsu_wb_ready` = 1, `rs1_busy` = 0, `rs2_busy` = 0.
  - Reset mid-operation drops FIFO contents and pending busy bits.
- Latency: a result selected in cycle N appears on the write port in cycle N+1. The register file updates at the end of N+1, and readers see the new value from N+2.
- Busy drops in cycle N+2 for a result selected in cycle N. A decode stage that waits for busy = 0 therefore always reads the new value.
- LSU direct path: latency 1. Result buffered behind an ALU write: latency 2 or more.
- Throughput: one register-file write per cycle. The FIFO never overflows because ready is low at count 2.
- Count 2 forces a drain. The ALU stalls for at least one cycle, so ALU traffic cannot starve the FIFO.

## Test plan
- Reset, then ALU writes x5 = 0x1234_5678 in cycle 1 → `write_en` = 1, `write_addr` = 5, `write_data` = 0x1234_5678 in cycle 2 only; all readies stay 1.
- Issue long op to x7, then LSU writes x7 = 0xDEAD_BEEF 3 cycles later with no ALU traffic → `rs1_busy` (rs1 = 7) is 1 from the cycle after issue until the LSU cycle + 1, and 0 from the LSU cycle + 2; write in the LSU cycle + 1.
- ALU writes x1 and LSU writes x2 in the same cycle, then ALU writes x3 → write order x1, x3, x2; count peaks at 1.
- Continuous ALU traffic with 3 LSU results → count reaches 2, both readies drop for one cycle and the FIFO head is written; the LSU result order is preserved.
- ALU write to x0 and LSU write to x0, plus issue to x0 → `write_en` stays 0 and `rs1_busy` (rs1 = 0) stays 0; both transfers complete.
- Fill the FIFO, then assert `rst_n` low mid-cycle → all outputs go to their reset values immediately (asynchronously); after release, no stale write appears.
